// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I main control FSM.
package multicycle_pkg;

    // Controller micro-step states
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Supported opcodes
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Memory address source
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A source
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B source
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALUOp handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_imm_src_decoder.sv
// Opcode to immediate-format decoder; formats without an immediate fall back to I.
module imm_src_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] ImmSrc
);

    // Select the immediate layout implied by the opcode
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences the shared datapath,
// handles the memory-ready handshake and counts retired instructions.
module multicycle_main_fsm
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             illegal_instr,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_r;
    state_t           state_next_s;
    logic             mem_req_s;
    logic             irwrite_s;
    logic             regwrite_s;
    logic             memwrite_s;
    logic             pcupdate_s;
    logic             branch_s;
    logic             retire_s;
    logic             illegal_r;
    logic [CNT_W-1:0] count_r;

    imm_src_decoder u_imm_src_decoder (
        .op     (op),
        .ImmSrc (ImmSrc)
    );

    // State register; reset restarts at FETCH and aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection; memory states hold until the access completes
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH:    if (mem_ready) state_next_s = DECODE; else state_next_s = FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_RTYPE:     state_next_s = EXECR;
                    OP_ITYPE:     state_next_s = EXECI;
                    OP_BEQ:       state_next_s = BEQ;
                    OP_JAL:       state_next_s = JAL;
                    default:      state_next_s = TRAP;
                endcase
            end
            MEMADR:   if (op == OP_LW) state_next_s = MEMREAD; else state_next_s = MEMWRITE;
            MEMREAD:  if (mem_ready) state_next_s = MEMWB; else state_next_s = MEMREAD;
            MEMWB:    state_next_s = FETCH;
            MEMWRITE: if (mem_ready) state_next_s = FETCH; else state_next_s = MEMWRITE;
            EXECR:    state_next_s = ALUWB;
            EXECI:    state_next_s = ALUWB;
            ALUWB:    state_next_s = FETCH;
            BEQ:      state_next_s = FETCH;
            JAL:      state_next_s = ALUWB;
            TRAP:     state_next_s = TRAP;
            default:  state_next_s = FETCH;
        endcase
    end

    // Per-state datapath controls; unlisted fields stay at zero
    always_comb begin
        mem_req_s  = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        pcupdate_s = 1'b0;
        branch_s   = 1'b0;
        retire_s   = 1'b0;
        AdrSrc     = ADR_PC;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_ADD;
        case (state_r)
            FETCH: begin
                mem_req_s  = 1'b1;
                irwrite_s  = mem_ready;
                pcupdate_s = mem_ready;
                AdrSrc     = ADR_PC;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ALUOp      = ALUOP_ADD;
                ResultSrc  = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            MEMREAD: begin
                mem_req_s = 1'b1;
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            MEMWRITE: begin
                mem_req_s  = 1'b1;
                AdrSrc     = ADR_RESULT;
                ResultSrc  = RES_ALUOUT;
                memwrite_s = 1'b1;
                retire_s   = mem_ready;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch_s  = 1'b1;
                retire_s  = 1'b1;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ALUOp      = ALUOP_ADD;
                ResultSrc  = RES_ALUOUT;
                pcupdate_s = 1'b1;
            end
            TRAP: begin
                mem_req_s = 1'b0;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Strobes are masked by reset so nothing writes while rst_n is low
    assign mem_req  = rst_n & mem_req_s;
    assign IRWrite  = rst_n & irwrite_s;
    assign RegWrite = rst_n & regwrite_s;
    assign MemWrite = rst_n & memwrite_s;
    assign PCWrite  = rst_n & (pcupdate_s | (branch_s & Zero));
    assign retire   = rst_n & retire_s;

    // Sticky illegal-instruction flag, set when DECODE diverts to TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if ((state_r == DECODE) && (state_next_s == TRAP)) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign illegal_instr = illegal_r;
    assign instr_count   = count_r;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed, table-driven bench for multicycle_main_fsm (counter width 4).
module tb_multicycle_main_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    // Output vector: mem_req PCWrite IRWrite RegWrite MemWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp retire
    localparam logic [14:0] E_RST  = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_FET  = 15'b1_1_1_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_FSTL = 15'b1_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_DEC  = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] E_MADR = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] E_MRD  = 15'b1_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] E_MWB  = 15'b0_0_0_1_0_0_01_00_00_00_1;
    localparam logic [14:0] E_MWRW = 15'b1_0_0_0_1_1_00_00_00_00_0;
    localparam logic [14:0] E_MWRD = 15'b1_0_0_0_1_1_00_00_00_00_1;
    localparam logic [14:0] E_EXR  = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] E_EXI  = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] E_AWB  = 15'b0_0_0_1_0_0_00_00_00_00_1;
    localparam logic [14:0] E_BEQT = 15'b0_1_0_0_0_0_00_10_00_01_1;
    localparam logic [14:0] E_BEQN = 15'b0_0_0_0_0_0_00_10_00_01_1;
    localparam logic [14:0] E_JAL  = 15'b0_1_0_0_0_0_00_01_10_00_0;
    localparam logic [14:0] E_ZERO = 15'b0;

    typedef struct packed {
        logic [6:0]  op;
        logic        z;
        logic        mr;
        logic [14:0] e;
        logic [1:0]  imm;
        logic [3:0]  cnt;
        logic        ill;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, pcwrite, irwrite, regwrite, memwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop, immsrc;
    logic       illegal_instr, retire;
    logic [3:0] instr_count;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t tbl[$];
    int   n_a;

    multicycle_main_fsm #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .Zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .PCWrite       (pcwrite),
        .IRWrite       (irwrite),
        .RegWrite      (regwrite),
        .MemWrite      (memwrite),
        .AdrSrc        (adrsrc),
        .ResultSrc     (resultsrc),
        .ALUSrcA       (alusrca),
        .ALUSrcB       (alusrcb),
        .ALUOp         (aluop),
        .ImmSrc        (immsrc),
        .illegal_instr (illegal_instr),
        .retire        (retire),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] outs();
        return {mem_req, pcwrite, irwrite, regwrite, memwrite, adrsrc,
                resultsrc, alusrca, alusrcb, aluop, retire};
    endfunction

    function automatic vec_t mk(input logic [6:0] o, input logic z, input logic mr,
                                input logic [14:0] e, input logic [1:0] imm,
                                input logic [3:0] cnt, input logic ill);
        vec_t v;
        v.op = o; v.z = z; v.mr = mr; v.e = e; v.imm = imm; v.cnt = cnt; v.ill = ill;
        return v;
    endfunction

    // Apply one row's inputs, compare at the falling edge, advance one cycle
    task automatic chk_row(input int idx, input vec_t v);
        logic [14:0] act;
        op = v.op; zero = v.z; mem_ready = v.mr;
        @(negedge clk);
        act = outs();
        n_cmp++;
        if (act !== v.e || immsrc !== v.imm || instr_count !== v.cnt || illegal_instr !== v.ill) begin
            n_fail++;
            $display("FAIL row%0d: got outs=%b imm=%b cnt=%0d ill=%b, want outs=%b imm=%b cnt=%0d ill=%b",
                     idx, act, immsrc, instr_count, illegal_instr, v.e, v.imm, v.cnt, v.ill);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        // Part A: one continuous instruction stream from reset
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_FET,  2'b00, 4'd0, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_DEC,  2'b00, 4'd0, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_MADR, 2'b00, 4'd0, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_MRD,  2'b00, 4'd0, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_MWB,  2'b00, 4'd0, 1'b0));
        tbl.push_back(mk(BQ, 1'b0, 1'b1, E_FET,  2'b10, 4'd1, 1'b0));
        tbl.push_back(mk(BQ, 1'b0, 1'b1, E_DEC,  2'b10, 4'd1, 1'b0));
        tbl.push_back(mk(BQ, 1'b1, 1'b1, E_BEQT, 2'b10, 4'd1, 1'b0));
        tbl.push_back(mk(BQ, 1'b0, 1'b1, E_FET,  2'b10, 4'd2, 1'b0));
        tbl.push_back(mk(BQ, 1'b0, 1'b1, E_DEC,  2'b10, 4'd2, 1'b0));
        tbl.push_back(mk(BQ, 1'b0, 1'b1, E_BEQN, 2'b10, 4'd2, 1'b0));
        tbl.push_back(mk(RT, 1'b0, 1'b1, E_FET,  2'b00, 4'd3, 1'b0));
        tbl.push_back(mk(RT, 1'b0, 1'b0, E_DEC,  2'b00, 4'd3, 1'b0));
        tbl.push_back(mk(RT, 1'b1, 1'b0, E_EXR,  2'b00, 4'd3, 1'b0));
        tbl.push_back(mk(RT, 1'b0, 1'b1, E_AWB,  2'b00, 4'd3, 1'b0));
        tbl.push_back(mk(IT, 1'b0, 1'b1, E_FET,  2'b00, 4'd4, 1'b0));
        tbl.push_back(mk(IT, 1'b0, 1'b1, E_DEC,  2'b00, 4'd4, 1'b0));
        tbl.push_back(mk(IT, 1'b0, 1'b1, E_EXI,  2'b00, 4'd4, 1'b0));
        tbl.push_back(mk(IT, 1'b0, 1'b0, E_AWB,  2'b00, 4'd4, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_FET,  2'b01, 4'd5, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_DEC,  2'b01, 4'd5, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_MADR, 2'b01, 4'd5, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(SW, 1'b0, 1'b0, E_MWRW, 2'b01, 4'd5, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_MWRD, 2'b01, 4'd5, 1'b0));
        tbl.push_back(mk(JL, 1'b0, 1'b1, E_FET,  2'b11, 4'd6, 1'b0));
        tbl.push_back(mk(JL, 1'b0, 1'b1, E_DEC,  2'b11, 4'd6, 1'b0));
        tbl.push_back(mk(JL, 1'b0, 1'b1, E_JAL,  2'b11, 4'd6, 1'b0));
        tbl.push_back(mk(JL, 1'b0, 1'b1, E_AWB,  2'b11, 4'd6, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b0, E_FSTL, 2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_FET,  2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_DEC,  2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_MADR, 2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b0, E_MRD,  2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_MRD,  2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(LW, 1'b0, 1'b1, E_MWB,  2'b00, 4'd7, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_FET,  2'b01, 4'd8, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_DEC,  2'b01, 4'd8, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b1, E_MADR, 2'b01, 4'd8, 1'b0));
        tbl.push_back(mk(SW, 1'b0, 1'b0, E_MWRW, 2'b01, 4'd8, 1'b0));
        n_a = tbl.size();
        // Part B: after the mid-store reset, one beq then an illegal opcode
        tbl.push_back(mk(BQ,  1'b0, 1'b1, E_FET,  2'b10, 4'd0, 1'b0));
        tbl.push_back(mk(BQ,  1'b0, 1'b1, E_DEC,  2'b10, 4'd0, 1'b0));
        tbl.push_back(mk(BQ,  1'b1, 1'b1, E_BEQT, 2'b10, 4'd0, 1'b0));
        tbl.push_back(mk(BAD, 1'b0, 1'b1, E_FET,  2'b00, 4'd1, 1'b0));
        tbl.push_back(mk(BAD, 1'b0, 1'b1, E_DEC,  2'b00, 4'd1, 1'b0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(BAD, 1'b1, i[0], E_ZERO, 2'b00, 4'd1, 1'b1));

        // Reset state
        rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {17'd0, outs()}, {17'd0, E_RST});
        chk("reset_cnt_ill", {27'd0, instr_count, illegal_instr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < n_a; i++) chk_row(i, tbl[i]);

        // Reset asserted mid-MEMWRITE (store still waiting on memory)
        mem_ready = 1'b0;
        #1;
        chk("memwrite_before_abort", {31'd0, memwrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {26'd0, memwrite, mem_req, retire, pcwrite, regwrite, irwrite}, 32'd0);
        chk("abort_cnt", {28'd0, instr_count}, 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_held_cnt_memwrite", {27'd0, instr_count, memwrite}, 32'd0);
        rst_n = 1'b1;

        for (int i = n_a; i < tbl.size(); i++) chk_row(i, tbl[i]);

        // Reset out of TRAP clears the sticky flag
        rst_n = 1'b0;
        #1;
        chk("trap_reset_ill", {31'd0, illegal_instr}, 32'd0);
        chk("trap_reset_outs", {17'd0, outs()}, {17'd0, E_RST});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 16 I-type instructions wrap the 4-bit counter back to 0
        for (int k = 0; k < 16; k++) begin
            chk_row(1000 + 4*k, mk(IT, 1'b0, 1'b1, E_FET, 2'b00, 4'(k), 1'b0));
            chk_row(1001 + 4*k, mk(IT, 1'b0, 1'b1, E_DEC, 2'b00, 4'(k), 1'b0));
            chk_row(1002 + 4*k, mk(IT, 1'b0, 1'b1, E_EXI, 2'b00, 4'(k), 1'b0));
            chk_row(1003 + 4*k, mk(IT, 1'b0, 1'b1, E_AWB, 2'b00, 4'(k), 1'b0));
        end
        chk_row(2000, mk(IT, 1'b0, 1'b1, E_FET, 2'b00, 4'd0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
